// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache (256 lines x 16 bytes).
// Answers the fetch stage's valid/addr_ok/data_ok request interface. Misses are
// refilled one whole line at a time through the bridge's line-read interface.
module icache (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_valid,
    input  logic        inst_op,
    input  logic [7:0]  inst_index,
    input  logic [19:0] inst_tag,
    input  logic [3:0]  inst_offset,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL
    } state_t;

    state_t      r_state;

    // Request latch: the request currently being looked up or refilled.
    logic [19:0] r_req_tag;
    logic [7:0]  r_req_index;
    logic [1:0]  r_req_word;

    // Refill beat counter and line assembly buffer.
    logic [1:0]  r_cnt;
    logic [31:0] r_buf [0:3];

    // Cache arrays; only the valid bits carry reset.
    logic [255:0] r_valid;
    logic [19:0]  r_tag_arr  [0:255];
    logic [31:0]  r_data_arr [0:1023];

    logic        w_hit;
    logic        w_handshake;
    logic        w_fill_done;
    logic [31:0] w_hit_word;
    logic [31:0] w_line [0:3];
    logic        w_unused;

    // Reads and word offset bits [1:0] are not distinguished by this cache.
    assign w_unused = &{1'b0, inst_op, inst_offset[1:0]};

    assign w_hit       = r_valid[r_req_index] && (r_tag_arr[r_req_index] == r_req_tag);
    assign w_hit_word  = r_data_arr[{r_req_index, r_req_word}];
    assign w_handshake = inst_valid && inst_addr_ok;
    assign w_fill_done = (r_state == S_REFILL) && ret_valid && ret_last;

    // The hit decision reads the arrays in the LOOKUP cycle itself, so the
    // handshake outputs are decoded from the registered state plus the lookup;
    // gating with resetn keeps every output quiet while reset is held.
    always_comb begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        rd_req       = 1'b0;
        if (resetn) begin
            case (r_state)
                S_IDLE: begin
                    inst_addr_ok = 1'b1;
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        inst_addr_ok = 1'b1;
                        inst_data_ok = 1'b1;
                        inst_rdata   = w_hit_word;
                    end
                end
                S_MISS: begin
                    rd_req = 1'b1;
                end
                default: begin
                    inst_addr_ok = 1'b0;
                end
            endcase
        end
    end

    assign rd_type = 3'b100;
    assign rd_addr = {r_req_tag, r_req_index, 4'b0000};

    // Line image written on the final beat: the beat arriving now overrides
    // the buffer slot the counter points at.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_line[i] = (r_cnt == 2'(i)) ? ret_data : r_buf[i];
        end
    end

    // Control FSM: request latch, beat counter and valid bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_req_tag   <= '0;
            r_req_index <= '0;
            r_req_word  <= '0;
            r_cnt       <= '0;
            r_valid     <= '0;
        end else begin
            if (w_handshake) begin
                r_req_tag   <= inst_tag;
                r_req_index <= inst_index;
                r_req_word  <= inst_offset[3:2];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!w_hit) begin
                        r_state <= S_MISS;
                    end else if (!w_handshake) begin
                        r_state <= S_IDLE;
                    end
                end
                S_MISS: begin
                    if (rd_rdy) begin
                        r_cnt   <= '0;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (ret_last) begin
                            r_valid[r_req_index] <= 1'b1;
                            r_state              <= S_LOOKUP;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Unreset storage: beat buffer, tag array and data array writes.
    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && ret_valid) begin
            r_buf[r_cnt] <= ret_data;
        end
        if (w_fill_done) begin
            r_tag_arr[r_req_index] <= r_req_tag;
            for (int unsigned i = 0; i < 4; i++) begin
                r_data_arr[{r_req_index, 2'(i)}] <= w_line[i];
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed requests and bridge behaviour, checked against
// a line-level cache model and an expected-response queue.
`timescale 1ns/1ps
module tb_icache;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_valid = 1'b0;
    logic        inst_op = 1'b0;
    logic [7:0]  inst_index = '0;
    logic [19:0] inst_tag = '0;
    logic [3:0]  inst_offset = '0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = '0;

    icache dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_valid   (inst_valid),
        .inst_op      (inst_op),
        .inst_index   (inst_index),
        .inst_tag     (inst_tag),
        .inst_offset  (inst_offset),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .rd_req       (rd_req),
        .rd_type      (rd_type),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Cache model: what each line holds once a refill has completed.
    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [31:0] m_line  [256][4];

    // Expected responses in order, with the cycle each must appear in.
    logic [31:0] exp_q[$];
    int          exp_cyc[$];

    // Outstanding miss.
    bit          miss_pend = 1'b0;
    logic [31:0] miss_addr = '0;
    int          miss_word = 0;

    // Observations used by the literal checks.
    int          ok_cyc[$];
    logic [31:0] ok_dat[$];
    int          acc_cyc = 0;
    int          req_cyc = 0;
    logic [31:0] last_rd_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Data the bridge returns for a line; the boot line uses the plan's values.
    function automatic logic [31:0] line_word(input logic [31:0] a, input int w);
        if (a == 32'hbfc00000) return 32'h11 * (w + 1);
        return a ^ 32'h5a5a_0000 ^ 32'(w * 4 + 1);
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (inst_data_ok) begin
            ok_cyc.push_back(cyc);
            ok_dat.push_back(inst_rdata);
            if (exp_q.size() == 0) begin
                chk("unexpected data_ok", {31'b0, inst_data_ok}, 32'd0);
            end else begin
                chk("rdata", inst_rdata, exp_q.pop_front());
                chk("data_ok cycle", cyc, exp_cyc.pop_front());
            end
        end else begin
            chk("rdata zero when idle", inst_rdata, 32'd0);
            if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc)
                chk("data_ok missing", {31'b0, inst_data_ok}, 32'd1);
        end
        if (rd_req) begin
            chk("rd_req only on miss", {31'b0, miss_pend}, 32'd1);
            chk("rd_addr", rd_addr, miss_addr);
            chk("rd_type", {29'b0, rd_type}, 32'd4);
        end
    end

    task automatic idle();
        inst_valid = 1'b0;
    endtask

    // Present one request and wait (bounded) for its handshake.
    task automatic fetch(input logic [31:0] a);
        bit acc = 1'b0;
        int idx;
        int w;
        inst_valid  = 1'b1;
        inst_tag    = a[31:12];
        inst_index  = a[11:4];
        inst_offset = a[3:0];
        inst_op     = ~inst_op;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = inst_addr_ok;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        chk("request accepted", {31'b0, acc}, 32'd1);
        if (acc) begin
            idx = int'(a[11:4]);
            w   = int'(a[3:2]);
            if (m_valid[idx] && m_tag[idx] == a[31:12]) begin
                exp_q.push_back(m_line[idx][w]);
                exp_cyc.push_back(acc_cyc + 1);
            end else begin
                miss_pend = 1'b1;
                miss_addr = {a[31:4], 4'b0000};
                miss_word = w;
            end
        end
    endtask

    // Bridge: wait for rd_req, stall, then return nbeats (optionally reset after).
    task automatic serve(input int stall, input int nbeats, input bit rst_after);
        bit seen = 1'b0;
        logic [31:0] a0;
        int idx;
        int r_cyc;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rd_req;
            if (seen) req_cyc = cyc;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rd_req raised", {31'b0, seen}, 32'd1);
        if (!seen) return;
        a0 = rd_addr;
        last_rd_addr = a0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rd_req held", {31'b0, rd_req}, 32'd1);
            chk("rd_addr held", rd_addr, a0);
            chk("addr_ok low in miss", {31'b0, inst_addr_ok}, 32'd0);
        end
        rd_rdy = 1'b1;
        @(posedge clk);
        #1;
        rd_rdy = 1'b0;
        r_cyc = cyc;
        for (int b = 0; b < nbeats; b++) begin
            ret_valid = 1'b1;
            ret_data  = line_word(a0, b);
            ret_last  = (b == nbeats - 1) && !rst_after;
            r_cyc     = cyc;
            @(negedge clk);
            chk("addr_ok low in refill", {31'b0, inst_addr_ok}, 32'd0);
            @(posedge clk);
            #1;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        idx = int'(a0[11:4]);
        if (rst_after) begin
            resetn = 1'b0;
            miss_pend = 1'b0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            @(negedge clk);
            chk("addr_ok low in reset", {31'b0, inst_addr_ok}, 32'd0);
            @(posedge clk);
            #1;
            resetn = 1'b1;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a0[31:12];
            for (int b = 0; b < 4; b++)
                m_line[idx][b] = (b < nbeats) ? line_word(a0, b) : 'x;
            exp_q.push_back(m_line[idx][miss_word]);
            exp_cyc.push_back(r_cyc + 1);
            miss_pend = 1'b0;
        end
    endtask

    initial begin
        int n;
        foreach (m_valid[i]) m_valid[i] = 1'b0;

        // Reset held for three cycles.
        #1 resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("addr_ok in reset", {31'b0, inst_addr_ok}, 32'd0);
            chk("rd_req in reset", {31'b0, rd_req}, 32'd0);
            chk("rd_addr in reset", rd_addr, 32'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("addr_ok after reset", {31'b0, inst_addr_ok}, 32'd1);
        @(posedge clk);
        #1;

        // Cold miss, then back-to-back hits starting in the re-lookup cycle.
        fetch(32'hbfc00004);
        idle();
        serve(0, 4, 1'b0);
        chk("cold miss rd_req latency", req_cyc, acc_cyc + 2);
        chk("cold miss rd_addr", last_rd_addr, 32'hbfc00000);
        fetch(32'hbfc00000);
        fetch(32'hbfc00008);
        fetch(32'hbfc0000c);
        idle();
        @(negedge clk);
        #1;
        n = ok_dat.size();
        chk("response count", n, 4);
        if (n >= 4) begin
            chk("cold miss word", ok_dat[n-4], 32'h22);
            chk("hit word0", ok_dat[n-3], 32'h11);
            chk("hit word2", ok_dat[n-2], 32'h33);
            chk("hit word3", ok_dat[n-1], 32'h44);
            chk("hits consecutive", ok_cyc[n-1] - ok_cyc[n-4], 32'd3);
        end
        @(posedge clk);
        #1;

        // Conflict miss on index 0 with a slow bridge, then the old line misses again.
        fetch(32'hbfd00004);
        idle();
        serve(5, 4, 1'b0);
        chk("conflict rd_addr", last_rd_addr, 32'hbfd00000);
        fetch(32'hbfc00004);
        idle();
        serve(0, 4, 1'b0);
        chk("re-miss rd_addr", last_rd_addr, 32'hbfc00000);
        fetch(32'hbfc00007);
        idle();

        // Early ret_last on a different index: received words are usable.
        fetch(32'h00001014);
        idle();
        serve(1, 2, 1'b0);
        fetch(32'h00001010);
        fetch(32'h00001017);
        idle();
        @(posedge clk);
        #1;

        // Reset in the middle of a refill, stray beats, then the same address misses.
        fetch(32'h00001024);
        idle();
        serve(0, 2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1;
            ret_data  = 32'hdead_0000 + 32'(i);
            ret_last  = (i == 1);
            @(negedge clk);
            chk("no rd_req on stray beat", {31'b0, rd_req}, 32'd0);
            @(posedge clk);
            #1;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        fetch(32'h00001024);
        idle();
        serve(0, 4, 1'b0);
        chk("post-reset rd_addr", last_rd_addr, 32'h00001020);
        fetch(32'hbfc00000);
        idle();
        serve(0, 4, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("all responses delivered", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

endmodule
